// File: rtl/key_cmd_queue_pkg.sv
// rtl/key_cmd_queue_pkg.sv - direction constants and key-to-direction mapping
package key_cmd_queue_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_RIGHT = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_UP    = 2'd2;
   localparam dir_t DIR_LEFT  = 2'd3;

   // Lowest set key bit wins; simultaneous higher bits are ignored.
   function automatic dir_t key_to_dir(input logic [3:0] key);
      dir_t d;
      d = DIR_RIGHT;
      if (key[0])      d = DIR_RIGHT;
      else if (key[1]) d = DIR_DOWN;
      else if (key[2]) d = DIR_UP;
      else if (key[3]) d = DIR_LEFT;
      return d;
   endfunction

endpackage

// File: rtl/key_cmd_queue_sync_fifo.sv
// rtl/key_cmd_queue_sync_fifo.sv - synchronous FIFO with flush and occupancy count
module sync_fifo #(
   parameter  int WIDTH = 2,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr;
   logic             w_rd;

   assign w_wr = i_push && !i_flush;
   assign w_rd = i_pop  && !i_flush;

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointers are power-of-two wide, so the natural overflow is the modulo wrap.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/key_cmd_queue.sv
// rtl/key_cmd_queue.sv - key pulse to direction command queue with dedupe and stale discard
module key_cmd_queue
   import key_cmd_queue_pkg::*;
#(
   parameter  int DEPTH        = 4,
   parameter  int STALE_CYCLES = 25000000,
   parameter  int CNT_W        = 25,
   localparam int CW           = $clog2(DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_resetn,
   input  logic [3:0]    i_key_pulse,
   input  logic          i_flush,
   input  logic          i_ovf_clr,
   input  logic          i_cmd_ready,
   output logic          o_cmd_valid,
   output logic [1:0]    o_cmd_dir,
   output logic [CW-1:0] o_count,
   output logic          o_overflow,
   output logic          o_stale_drop
);

   localparam bit               STALE_EN   = (STALE_CYCLES != 0);
   localparam logic [CNT_W-1:0] STALE_LAST = CNT_W'(STALE_CYCLES - 1);

   logic             r_overflow;
   logic             r_stale_drop;
   logic [CNT_W-1:0] r_stale_cnt;
   dir_t             r_last_dir;

   logic             w_cand_valid;
   dir_t             w_cand_dir;
   logic             w_survive;
   logic             w_accept;
   logic             w_stale_hit;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic             w_full;
   logic             w_empty;
   dir_t             w_rdata;

   assign w_cand_valid = |i_key_pulse;
   assign w_cand_dir   = key_to_dir(i_key_pulse);
   assign w_survive    = w_cand_valid && (w_empty || (w_cand_dir != r_last_dir));

   assign w_accept     = o_cmd_valid && i_cmd_ready;
   assign w_stale_hit  = STALE_EN && o_cmd_valid && !i_cmd_ready && (r_stale_cnt == STALE_LAST);
   assign w_pop        = (w_accept || w_stale_hit) && !i_flush;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign w_push       = w_survive && (!w_full || w_pop) && !i_flush;
   assign w_drop       = w_survive && w_full && !w_pop && !i_flush;

   sync_fifo #(
      .WIDTH (2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_flush  (i_flush),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .i_wdata  (w_cand_dir),
      .o_rdata  (w_rdata),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_count  (o_count)
   );

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_overflow   <= 1'b0;
         r_stale_drop <= 1'b0;
         r_stale_cnt  <= '0;
         r_last_dir   <= DIR_RIGHT;
      end else begin
         if (w_drop)         r_overflow <= 1'b1;
         else if (i_ovf_clr) r_overflow <= 1'b0;

         r_stale_drop <= w_stale_hit && !i_flush;

         if (i_flush || w_pop || w_empty) r_stale_cnt <= '0;
         else if (!i_cmd_ready)           r_stale_cnt <= r_stale_cnt + CNT_W'(1);

         if (w_push) r_last_dir <= w_cand_dir;
      end
   end

   assign o_cmd_valid  = !w_empty;
   assign o_cmd_dir    = o_cmd_valid ? w_rdata : DIR_RIGHT;
   assign o_overflow   = r_overflow;
   assign o_stale_drop = r_stale_drop;

endmodule

// File: tb/tb_key_cmd_queue.sv
// tb/tb_key_cmd_queue.sv - directed self-checking bench for key_cmd_queue
module tb_key_cmd_queue;

   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] key_pulse = 4'd0;
   logic       flush = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd_dir;
   logic [2:0] count;
   logic       overflow;
   logic       stale_drop;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   key_cmd_queue #(
      .DEPTH        (4),
      .STALE_CYCLES (8),
      .CNT_W        (4)
   ) dut (
      .i_clk        (clk),
      .i_resetn     (resetn),
      .i_key_pulse  (key_pulse),
      .i_flush      (flush),
      .i_ovf_clr    (ovf_clr),
      .i_cmd_ready  (cmd_ready),
      .o_cmd_valid  (cmd_valid),
      .o_cmd_dir    (cmd_dir),
      .o_count      (count),
      .o_overflow   (overflow),
      .o_stale_drop (stale_drop)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] k, input logic rdy);
      key_pulse = k;
      cmd_ready = rdy;
      tick();
      key_pulse = 4'd0;
      cmd_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      #2 resetn = 1'b0;
      #1;
      n_total++;
      if ({cmd_valid, cmd_dir, count, overflow, stale_drop} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_outputs got=%b exp=00000000", {cmd_valid, cmd_dir, count, overflow, stale_drop});
      end
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_single_press();
      drive(4'b0100, 1'b0);
      n_total++;
      if ({cmd_valid, cmd_dir, count} !== {1'b1, 2'd2, 3'd1}) begin
         n_bad++;
         $display("FAIL single_push got v=%b d=%0d c=%0d exp v=1 d=2 c=1", cmd_valid, cmd_dir, count);
      end
      drive(4'b0000, 1'b1);
      n_total++;
      if ({cmd_valid, count} !== {1'b0, 3'd0}) begin
         n_bad++;
         $display("FAIL single_pop got v=%b c=%0d exp v=0 c=0", cmd_valid, count);
      end
   endtask

   task automatic test_priority_dedupe();
      drive(4'b1010, 1'b0);
      n_total++;
      if ({cmd_dir, count} !== {2'd1, 3'd1}) begin
         n_bad++;
         $display("FAIL prio_push got d=%0d c=%0d exp d=1 c=1", cmd_dir, count);
      end
      drive(4'b0010, 1'b0);
      n_total++;
      if (count !== 3'd1) begin
         n_bad++;
         $display("FAIL dedupe_drop got c=%0d exp c=1", count);
      end
      drive(4'b0000, 1'b1);
      drive(4'b0010, 1'b0);
      n_total++;
      if ({cmd_valid, cmd_dir, count} !== {1'b1, 2'd1, 3'd1}) begin
         n_bad++;
         $display("FAIL dedupe_empty_accept got v=%b d=%0d c=%0d exp v=1 d=1 c=1", cmd_valid, cmd_dir, count);
      end
      drive(4'b0000, 1'b1);
   endtask

   task automatic test_overflow();
      logic [1:0] exp_heads [4];
      exp_heads = '{2'd2, 2'd3, 2'd0, 2'd0};
      drive(4'b0001, 1'b0);
      drive(4'b0010, 1'b0);
      drive(4'b0100, 1'b0);
      drive(4'b1000, 1'b0);
      n_total++;
      if ({count, cmd_dir, overflow} !== {3'd4, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL fill got c=%0d d=%0d o=%b exp c=4 d=0 o=0", count, cmd_dir, overflow);
      end
      drive(4'b0001, 1'b0);
      n_total++;
      if ({count, overflow} !== {3'd4, 1'b1}) begin
         n_bad++;
         $display("FAIL full_drop got c=%0d o=%b exp c=4 o=1", count, overflow);
      end
      ovf_clr = 1'b1;
      drive(4'b0001, 1'b0);
      ovf_clr = 1'b0;
      n_total++;
      if (overflow !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_set_wins got o=%b exp o=1", overflow);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      n_total++;
      if (overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_clear got o=%b exp o=0", overflow);
      end
      drive(4'b0001, 1'b1);
      n_total++;
      if ({count, cmd_dir, overflow} !== {3'd4, 2'd1, 1'b0}) begin
         n_bad++;
         $display("FAIL full_push_pop got c=%0d d=%0d o=%b exp c=4 d=1 o=0", count, cmd_dir, overflow);
      end
      for (int i = 0; i < 3; i++) begin
         drive(4'b0000, 1'b1);
         n_total++;
         if ({cmd_valid, cmd_dir} !== {1'b1, exp_heads[i]}) begin
            n_bad++;
            $display("FAIL drain_head%0d got v=%b d=%0d exp v=1 d=%0d", i, cmd_valid, cmd_dir, exp_heads[i]);
         end
      end
      drive(4'b0000, 1'b1);
      n_total++;
      if ({cmd_valid, count} !== {1'b0, 3'd0}) begin
         n_bad++;
         $display("FAIL drain_empty got v=%b c=%0d exp v=0 c=0", cmd_valid, count);
      end
   endtask

   task automatic test_stale();
      drive(4'b0100, 1'b0);
      for (int i = 1; i <= 7; i++) begin
         tick();
         n_total++;
         if ({stale_drop, cmd_valid, count} !== {1'b0, 1'b1, 3'd1}) begin
            n_bad++;
            $display("FAIL stale_wait%0d got s=%b v=%b c=%0d exp s=0 v=1 c=1", i, stale_drop, cmd_valid, count);
         end
      end
      tick();
      n_total++;
      if ({stale_drop, cmd_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
         n_bad++;
         $display("FAIL stale_expire got s=%b v=%b c=%0d exp s=1 v=0 c=0", stale_drop, cmd_valid, count);
      end
      tick();
      n_total++;
      if (stale_drop !== 1'b0) begin
         n_bad++;
         $display("FAIL stale_pulse_width got s=%b exp s=0", stale_drop);
      end
      drive(4'b0100, 1'b0);
      for (int i = 1; i <= 7; i++) tick();
      drive(4'b0000, 1'b1);
      n_total++;
      if ({stale_drop, cmd_valid, count} !== {1'b0, 1'b0, 3'd0}) begin
         n_bad++;
         $display("FAIL stale_ready_accept got s=%b v=%b c=%0d exp s=0 v=0 c=0", stale_drop, cmd_valid, count);
      end
      tick();
      n_total++;
      if (stale_drop !== 1'b0) begin
         n_bad++;
         $display("FAIL stale_ready_no_pulse got s=%b exp s=0", stale_drop);
      end
   endtask

   task automatic test_flush();
      drive(4'b0001, 1'b0);
      drive(4'b0010, 1'b0);
      drive(4'b0100, 1'b0);
      drive(4'b1000, 1'b0);
      drive(4'b0001, 1'b0);
      drive(4'b0000, 1'b1);
      n_total++;
      if ({count, overflow} !== {3'd3, 1'b1}) begin
         n_bad++;
         $display("FAIL flush_setup got c=%0d o=%b exp c=3 o=1", count, overflow);
      end
      flush = 1'b1;
      drive(4'b0001, 1'b1);
      flush = 1'b0;
      n_total++;
      if ({count, cmd_valid, overflow} !== {3'd0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL flush got c=%0d v=%b o=%b exp c=0 v=0 o=1", count, cmd_valid, overflow);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
   endtask

   task automatic test_async_reset();
      drive(4'b0001, 1'b0);
      drive(4'b0010, 1'b0);
      n_total++;
      if (count !== 3'd2) begin
         n_bad++;
         $display("FAIL areset_setup got c=%0d exp c=2", count);
      end
      #2 resetn = 1'b0;
      #1;
      n_total++;
      if ({cmd_valid, cmd_dir, count, overflow, stale_drop} !== 8'h00) begin
         n_bad++;
         $display("FAIL areset_immediate got=%b exp=00000000", {cmd_valid, cmd_dir, count, overflow, stale_drop});
      end
      tick();
      resetn = 1'b1;
      tick();
      drive(4'b0010, 1'b0);
      n_total++;
      if ({cmd_valid, cmd_dir, count} !== {1'b1, 2'd1, 3'd1}) begin
         n_bad++;
         $display("FAIL areset_first_push got v=%b d=%0d c=%0d exp v=1 d=1 c=1", cmd_valid, cmd_dir, count);
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_priority_dedupe();
      test_overflow();
      test_stale();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
